conv2d_stream: RTL

CONV2D_STREAM -- requirements
Module: conv2d_stream

---
 rtl/conv2d_stream_pkg.sv | 27 ++
 rtl/conv2d_stream_if.sv | 24 ++
 rtl/conv2d_stream_line_buffer.sv | 41 ++++
 rtl/conv2d_stream.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/conv2d_stream_pkg.sv
// Fixed-point helpers shared by the convolution blocks: accumulator sizing and
// saturation classification of a wide signed result against a DATA_W range.
package conv_pkg;

  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_POS,
    SAT_NEG
  } sat_e;

  function automatic int acc_w(input int data_w, input int taps);
    return 2 * data_w + $clog2(taps) + 1;
  endfunction

  function automatic sat_e saturate(input logic signed [SAT_W-1:0] v, input int data_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return SAT_POS;
    if (v < lo) return SAT_NEG;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/conv2d_stream_if.sv
// Pixel input stream and result output stream of conv2d_stream (valid/ready on both).
// The slave side is the convolution block, the master side is its environment.
interface conv2d_stream_if #(
  parameter int DATA_W = 16,
  parameter int CIN    = 1
);
  logic [CIN*DATA_W-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  frame_done;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, frame_done
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, frame_done
  );
endinterface

// File: rtl/conv2d_stream_line_buffer.sv
// conv_line_buffer: ROWS previous image rows, one column slot per pixel position, shifted
// vertically at the current column on each accepted pixel; taps are combinational (0 latency).
module conv_line_buffer #(
  parameter int PIX_W = 16,
  parameter int W     = 28,
  parameter int ROWS  = 2,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en_i,
  input  logic [CW-1:0]    col_i,
  input  logic [PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0] taps_o [ROWS]
);

  logic [PIX_W-1:0] mem_q [ROWS][W];

  // taps_o[0] is the row just above the incoming pixel, taps_o[ROWS-1] the oldest row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < W; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (shift_en_i) begin
      mem_q[0][col_i] <= pix_i;
      for (int r = 1; r < ROWS; r++) begin
        mem_q[r][col_i] <= mem_q[r-1][col_i];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      taps_o[r] = mem_q[r][col_i];
    end
  end

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming KxK, stride-S, CIN-channel convolution; result one cycle after the window-completing pixel,
// input stalls (in_ready low) while the single output register is full and not taken. CONV_RELU_EN clamps negatives to 0.
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int W      = 28,
  parameter int H      = 28,
  parameter int K      = 3,
  parameter int S      = 1,
  parameter int CIN    = 1
) (
  input  logic                        clk,
  input  logic                        global_rst_n,
  conv2d_stream_if.slave              bus,
  input  logic [CIN*K*K*DATA_W-1:0]   weight,
  input  logic [DATA_W-1:0]           bias
);

  localparam int PIX_W    = CIN * DATA_W;
  localparam int ACC_W    = acc_w(DATA_W, CIN * K * K);
  localparam int CW       = (W > 1) ? $clog2(W) : 1;
  localparam int RW       = (H > 1) ? $clog2(H) : 1;
  localparam int LB_ROWS  = (K > 1) ? K - 1 : 1;
  localparam int LAST_ROW = K - 1 + ((H - K) / S) * S;
  localparam int LAST_COL = K - 1 + ((W - K) / S) * S;

  logic                     in_xfer;
  logic                     out_xfer;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic [PIX_W-1:0]         win_q [K][K];
  logic [PIX_W-1:0]         win_d [K][K];
  logic [PIX_W-1:0]         taps  [LB_ROWS];
  logic                     win_ok;
  logic                     win_last;
  logic signed [DATA_W-1:0]   px;
  logic signed [DATA_W-1:0]   wt;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [SAT_W-1:0]  sat_in;
  sat_e                     sat;
  logic [DATA_W-1:0]        res;
  logic [DATA_W-1:0]        res_final;
  logic                     rdy_q;
  logic                     out_valid_q, out_valid_d;
  logic                     frame_done_q, frame_done_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;

  // rdy_q holds the input off until the first clock after reset release
  assign bus.in_ready   = rdy_q & (!out_valid_q | bus.out_ready);
  assign in_xfer        = bus.in_valid & bus.in_ready;
  assign out_xfer       = out_valid_q & bus.out_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;

  conv_line_buffer #(
    .PIX_W (PIX_W),
    .W     (W),
    .ROWS  (LB_ROWS),
    .CW    (CW)
  ) u_line_buffer (
    .clk        (clk),
    .rst_n      (global_rst_n),
    .shift_en_i (in_xfer),
    .col_i      (col_q),
    .pix_i      (bus.in_data),
    .taps_o     (taps)
  );

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_xfer) begin
      if (col_q == CW'(W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position of the incoming pixel decides whether it completes an output window
  assign win_ok = (int'(row_q) >= K - 1) && (int'(col_q) >= K - 1) &&
                  ((int'(row_q) - (K - 1)) % S == 0) &&
                  ((int'(col_q) - (K - 1)) % S == 0);
  assign win_last = (int'(row_q) == LAST_ROW) && (int'(col_q) == LAST_COL);

  always_comb begin
    win_d = win_q;
    if (in_xfer) begin
      for (int r = 0; r < K; r++) begin
        for (int k = 0; k < K - 1; k++) begin
          win_d[r][k] = win_q[r][k+1];
        end
      end
      for (int r = 0; r < K - 1; r++) begin
        win_d[r][K-1] = taps[K-2-r];
      end
      win_d[K-1][K-1] = bus.in_data;
    end
  end

  // MAC over the window as it will look after this pixel is shifted in
  always_comb begin
    px   = '0;
    wt   = '0;
    prod = '0;
    acc  = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} <<< FRAC_W;
    for (int c = 0; c < CIN; c++) begin
      for (int r = 0; r < K; r++) begin
        for (int k = 0; k < K; k++) begin
          px   = win_d[r][k][c*DATA_W +: DATA_W];
          wt   = weight[((c*K+r)*K+k)*DATA_W +: DATA_W];
          prod = px * wt;
          acc  = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
      end
    end
    acc_sh = acc >>> FRAC_W;
  end

  assign sat_in = SAT_W'(acc_sh);
  assign sat    = saturate(sat_in, DATA_W);

  always_comb begin
    res = acc_sh[DATA_W-1:0];
    case (sat)
      SAT_POS: res = {1'b0, {(DATA_W-1){1'b1}}};
      SAT_NEG: res = {1'b1, {(DATA_W-1){1'b0}}};
      default: res = acc_sh[DATA_W-1:0];
    endcase
  end

`ifdef CONV_RELU_EN
  assign res_final = res[DATA_W-1] ? '0 : res;
`else
  assign res_final = res;
`endif

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = frame_done_q;
    if (in_xfer && win_ok) begin
      out_valid_d  = 1'b1;
      out_data_d   = res_final;
      frame_done_d = win_last;
    end else if (out_xfer) begin
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      rdy_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int k = 0; k < K; k++) begin
          win_q[r][k] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      rdy_q        <= 1'b1;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

endmodule
